pwm_multi: RTL and testbench
============================

# pwm_multi

Parametrised multi-channel PWM generator: one shared period counter drives CHANNELS compare outputs. Each output has its own compare value and polarity. Supports fast (sawtooth) and phase-correct (triangle) counting. All configuration is double-buffered, so changes take effect only at a period boundary and never produce a runt pulse. The block sits between the register/control logic and the pins, replacing the single-channel 16-bit pwm.

## Interface
Parameters:
- WIDTH, 16, counter/top/compare width in bits
- CHANNELS, 4, number of PWM outputs

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; 0 freezes counter, dir, out and pending transfer
- load  in  1  single-cycle strobe; captures top, comp, pol, mode into pending registers
- mode  in  1  0 = fast, 1 = phase-correct (captured on load)
- top  in  WIDTH  period limit (captured on load)
- comp  in  CHANNELS*WIDTH  per-channel compare; channel i at bits [i*WIDTH +: WIDTH]
- pol  in  CHANNELS  per-channel polarity; 1 inverts the output
- out  out  CHANNELS  registered PWM outputs
- counter  out  WIDTH  current counter value
- busy  out  1  pending configuration not yet transferred
- sync  out  1  high while counter == 0 (period start)

## Operation
- Active set: top_a, comp_a[i], pol_a, mode_a. Pending set has the same fields plus a pend flag.
- Reset: every active and pending field = 0, pend = 0, counter = 0, dir = up, out = 0, busy = 0, sync = 1.
- load = 1 copies inputs into pending and sets pend. A new load while pend = 1 overwrites pending (latest wins).
- next_cnt is computed from the active set:
  - Fast mode: counter < top_a gives counter+1; otherwise 0.
  - Phase mode, dir up: counter < top_a gives counter+1. counter == top_a gives top_a-1 and dir = down; if top_a == 0, next_cnt = 0.
  - Phase mode, dir down: next_cnt = counter-1.
  - dir is forced to up whenever next_cnt == 0.
- Transfer happens on the edge where en = 1, next_cnt == 0 and pend = 1: active <= pending and pend <= 0. If load coincides with this edge, the new load values transfer directly.
- Mode change at transfer: the counter is already going to 0 and dir to up, so the new mode starts cleanly.
- Channel i output: out[i] = (counter < comp_a[i]) XOR pol_a[i].
  - Registered from next-state values, so out is aligned with counter in the same cycle.
  - comp = 0 gives constant inactive.
  - comp > top gives constant active.
- Periods: fast = top+1 cycles; phase = 2*top cycles (top ≥ 1). top = 0 in either mode holds counter at 0 and gives a boundary every cycle.
- Comparisons are unsigned at full WIDTH, with no wrap beyond top_a.

## Timing
- load to busy = 1: next cycle.
- Transfer latency: the first edge with en = 1 and next_cnt == 0, at most one full period.
- After reset the active top is 0, so the first load transfers on the edge following the load cycle.
- The cycle with counter == 0 already uses the new configuration (sync = 1 in that cycle).
- en = 0: all state holds and load is still captured. busy stays 1 until en resumes and the boundary is reached.
- rst mid-period: on the next edge all state returns to reset values and pending is discarded.
- No combinational path from any input to out, counter or busy.

## Structure
- pwm_pkg: mode constants MODE_FAST = 1'b0, MODE_PHASE = 1'b1; direction constants DIR_UP/DIR_DOWN.
- Sub-module pwm_channel: one instance per channel via generate. Contains the compare register, polarity and output flop, and takes next_cnt plus the transfer strobe.
- Top level pwm_multi: counter, dir, pending/active control.

## Test plan
- Fast mode, WIDTH = 16, top = 3, comp0 = 1, pol0 = 0 -> counter 0,1,2,3,0…; out0 1,0,0,0 repeating; sync every 4 cycles.
- Phase mode, top = 3, comp0 = 1 -> counter 0,1,2,3,2,1,0…; out0 1,0,0,0,0,0 repeating (period 6). With pol0 = 1 the pattern is inverted.
- Shadowing: fast, top = 16, comp = 1, then load comp = 8 at counter = 5 -> busy = 1 until counter wraps; the new duty applies from counter = 0; no intermediate glitch.
- Boundaries: comp = 0 -> out constant 0; comp = 17 with top = 16 -> out constant 1; top = 0 -> counter stuck at 0, sync constant 1.
- Channel independence: comp = {1,2,3,4}, pol = 4'b0101, top = 3 -> each channel shows its own duty with the correct inversion.
- Control: en = 0 at counter = 2 for 5 cycles -> counter, out and busy frozen. rst at counter = 7 with busy = 1 -> next cycle counter = 0, out = 0, busy = 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared mode and direction encodings for the multi-channel PWM block.
package pwm_pkg;
    typedef enum logic {MODE_FAST = 1'b0, MODE_PHASE = 1'b1} mode_t;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
endpackage

// File: rtl/pwm_channel.sv
// One PWM output: active compare/polarity and the output flop, fed by the
// shared next-counter value so the output lines up with the counter.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             xfer,
    input  logic [WIDTH-1:0] next_cnt,
    input  logic [WIDTH-1:0] comp_src,
    input  logic             pol_src,
    output logic             out
);
    logic [WIDTH-1:0] comp_a;
    logic             pol_a;
    logic [WIDTH-1:0] comp_nxt;
    logic             pol_nxt;

    // On a transfer edge the new compare already governs the counter-0 cycle.
    assign comp_nxt = xfer ? comp_src : comp_a;
    assign pol_nxt  = xfer ? pol_src  : pol_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            comp_a <= '0;
            pol_a  <= 1'b0;
            out    <= 1'b0;
        end else begin
            if (xfer) begin
                comp_a <= comp_src;
                pol_a  <= pol_src;
            end
            if (en) begin
                out <= (next_cnt < comp_nxt) ^ pol_nxt;
            end
        end
    end
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, double-buffered configuration.
// dir     | meaning
// DIR_UP  | counting toward top (always the case in fast mode)
// DIR_DOWN| phase-correct descent from top back to 0
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          top,
    input  logic [CHANNELS*WIDTH-1:0] comp,
    input  logic [CHANNELS-1:0]       pol,
    output logic [CHANNELS-1:0]       out,
    output logic [WIDTH-1:0]          counter,
    output logic                      busy,
    output logic                      sync
);
    logic [WIDTH-1:0]          cnt_q, next_cnt, top_a, top_p, top_src;
    mode_t                     mode_a, mode_p, mode_src;
    dir_t                      dir_q, next_dir;
    logic [CHANNELS*WIDTH-1:0] comp_p, comp_src;
    logic [CHANNELS-1:0]       pol_p, pol_src;
    logic                      pend;
    logic                      xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            top_a  <= '0;
            mode_a <= MODE_FAST;
            top_p  <= '0;
            mode_p <= MODE_FAST;
            comp_p <= '0;
            pol_p  <= '0;
            pend   <= 1'b0;
        end else begin
            if (load) begin
                top_p  <= top;
                mode_p <= mode_t'(mode);
                comp_p <= comp;
                pol_p  <= pol;
            end
            if (en) begin
                cnt_q <= next_cnt;
                dir_q <= next_dir;
            end
            if (xfer) begin
                top_a  <= top_src;
                mode_a <= mode_src;
                pend   <= 1'b0;
            end else if (load) begin
                pend <= 1'b1;
            end
        end
    end

    always_comb begin
        next_cnt = '0;
        next_dir = DIR_UP;
        if (mode_a == MODE_FAST) begin
            next_cnt = (cnt_q < top_a) ? cnt_q + WIDTH'(1) : '0;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q < top_a) begin
                next_cnt = cnt_q + WIDTH'(1);
            end else if (top_a != '0) begin
                next_cnt = top_a - WIDTH'(1);
                next_dir = DIR_DOWN;
            end
        end else begin
            next_cnt = cnt_q - WIDTH'(1);
            next_dir = DIR_DOWN;
        end
        if (next_cnt == '0) begin
            next_dir = DIR_UP;
        end
    end

    // A load on the transfer edge bypasses the pending registers.
    always_comb begin
        xfer     = en && pend && (next_cnt == '0);
        top_src  = load ? top : top_p;
        mode_src = load ? mode_t'(mode) : mode_p;
        comp_src = load ? comp : comp_p;
        pol_src  = load ? pol : pol_p;
        counter  = cnt_q;
        busy     = pend;
        sync     = (cnt_q == '0);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .xfer     (xfer),
            .next_cnt (next_cnt),
            .comp_src (comp_src[i*WIDTH +: WIDTH]),
            .pol_src  (pol_src[i]),
            .out      (out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed table, corner sequences,
// and randomized traffic against a period-position reference model.
module tb_pwm_multi;
    localparam int W  = 16;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic          mode = 1'b0;
    logic [W-1:0]  top = '0;
    logic [CH*W-1:0] comp = '0;
    logic [CH-1:0] pol = '0;
    logic [CH-1:0] out;
    logic [W-1:0]  counter;
    logic          busy;
    logic          sync;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .mode    (mode),
        .top     (top),
        .comp    (comp),
        .pol     (pol),
        .out     (out),
        .counter (counter),
        .busy    (busy),
        .sync    (sync)
    );

    typedef struct {
        logic          rst, en, load, mode;
        logic [W-1:0]  top;
        logic [CH*W-1:0] comp;
        logic [CH-1:0] pol;
        logic [W-1:0]  e_cnt;
        logic [CH-1:0] e_out;
        logic          e_busy, e_sync;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic m, input logic [W-1:0] t,
                              input logic [CH*W-1:0] c, input logic [CH-1:0] p);
        load = 1'b1; mode = m; top = t; comp = c; pol = p;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    function automatic vec_t mk(input logic r, e, l, m, input logic [W-1:0] t,
                                input logic [CH*W-1:0] c, input logic [CH-1:0] p,
                                input logic [W-1:0] ec, input logic [CH-1:0] eo,
                                input logic eb, es);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.mode = m; v.top = t; v.comp = c; v.pol = p;
        v.e_cnt = ec; v.e_out = eo; v.e_busy = eb; v.e_sync = es;
        return v;
    endfunction

    // Reference model: position within the period, counter derived from it.
    int   m_pos, m_top, a_top, p_top;
    bit   a_mode, p_mode, m_pend;
    int   a_comp[CH], p_comp[CH];
    bit   a_pol[CH], p_pol[CH];

    function automatic int plen(input int t, input bit m);
        if (t == 0) return 1;
        return m ? 2 * t : t + 1;
    endfunction

    function automatic int pcnt(input int p, input int t, input bit m);
        if (!m || p <= t) return p;
        return 2 * t - p;
    endfunction

    task automatic model_reset();
        m_pos = 0; a_top = 0; p_top = 0; a_mode = 0; p_mode = 0; m_pend = 0;
        for (int i = 0; i < CH; i++) begin
            a_comp[i] = 0; p_comp[i] = 0; a_pol[i] = 0; p_pol[i] = 0;
        end
    endtask

    task automatic model_step();
        int np;
        logic [W-1:0] cv;
        if (rst) begin
            model_reset();
            return;
        end
        np = (m_pos + 1) % plen(a_top, a_mode);
        if (en) m_pos = np;
        if (en && np == 0 && m_pend) begin
            a_top  = load ? int'(top) : p_top;
            a_mode = load ? mode : p_mode;
            for (int i = 0; i < CH; i++) begin
                cv = comp[i*W +: W];
                a_comp[i] = load ? int'(cv) : p_comp[i];
                a_pol[i]  = load ? pol[i] : p_pol[i];
            end
            m_pend = 0;
        end else if (load) begin
            m_pend = 1;
        end
        if (load) begin
            p_top = int'(top); p_mode = mode;
            for (int i = 0; i < CH; i++) begin
                cv = comp[i*W +: W];
                p_comp[i] = int'(cv);
                p_pol[i]  = pol[i];
            end
        end
    endtask

    function automatic logic [CH-1:0] model_out();
        logic [CH-1:0] o;
        int c;
        c = pcnt(m_pos, a_top, a_mode);
        for (int i = 0; i < CH; i++) o[i] = (c < a_comp[i]) ^ a_pol[i];
        return o;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CH*W-1:0] cmp4;
        int pc[6];
        int po[6];
        logic [CH-1:0] eo;
        int k;
        cmp4 = {16'd4, 16'd3, 16'd2, 16'd1};
        pc = '{0, 1, 2, 3, 2, 1};
        po = '{1, 0, 0, 0, 0, 0};

        tbl[0]  = mk(1, 0, 0, 0, 0, '0,   4'b0000, 0, 4'b0000, 0, 1);
        tbl[1]  = mk(0, 1, 1, 0, 3, cmp4, 4'b0101, 0, 4'b0000, 1, 1);
        tbl[2]  = mk(0, 1, 0, 0, 0, '0,   4'b0000, 0, 4'b1010, 0, 1);
        tbl[3]  = mk(0, 1, 0, 0, 0, '0,   4'b0000, 1, 4'b1011, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, '0,   4'b0000, 2, 4'b1001, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, '0,   4'b0000, 3, 4'b1101, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, '0,   4'b0000, 0, 4'b1010, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 0, '0,   4'b0000, 1, 4'b1011, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, '0,   4'b0000, 1, 4'b1011, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0, '0,   4'b0000, 1, 4'b1011, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, '0,   4'b0000, 1, 4'b1011, 1, 0);
        tbl[11] = mk(0, 1, 0, 0, 0, '0,   4'b0000, 2, 4'b1001, 1, 0);
        tbl[12] = mk(0, 1, 0, 0, 0, '0,   4'b0000, 3, 4'b1101, 1, 0);
        tbl[13] = mk(0, 1, 0, 0, 0, '0,   4'b0000, 0, 4'b0000, 0, 1);
        tbl[14] = mk(0, 1, 0, 0, 0, '0,   4'b0000, 0, 4'b0000, 0, 1);

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load; mode = tbl[i].mode;
            top = tbl[i].top; comp = tbl[i].comp; pol = tbl[i].pol;
            tick();
            check($sformatf("tbl%0d_counter", i), 32'(counter), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_out", i),     32'(out),     32'(tbl[i].e_out));
            check($sformatf("tbl%0d_busy", i),    32'(busy),    32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_sync", i),    32'(sync),    32'(tbl[i].e_sync));
        end
        load = 1'b0; en = 1'b1;

        // Phase-correct, normal then inverted polarity.
        drive_load(1'b1, 16'd3, 64'd1, 4'b0000);
        tick(); load = 1'b0;
        wait_idle("phase_xfer");
        for (int j = 0; j < 12; j++) begin
            check("phase_counter", 32'(counter), 32'(pc[j % 6]));
            check("phase_out0", 32'(out[0]), 32'(po[j % 6]));
            check("phase_sync", 32'(sync), 32'(pc[j % 6] == 0));
            tick();
        end
        drive_load(1'b1, 16'd3, 64'd1, 4'b0001);
        tick(); load = 1'b0;
        wait_idle("phase_inv_xfer");
        for (int j = 0; j < 6; j++) begin
            check("phase_inv_counter", 32'(counter), 32'(pc[j]));
            check("phase_inv_out0", 32'(out[0]), 32'(1 - po[j]));
            tick();
        end

        // Shadowing: new duty only from the next counter==0.
        drive_load(1'b0, 16'd16, 64'd1, 4'b0000);
        tick(); load = 1'b0;
        wait_idle("shadow_xfer");
        repeat (5) tick();
        check("shadow_at5", 32'(counter), 32'd5);
        drive_load(1'b0, 16'd16, 64'd8, 4'b0000);
        tick(); load = 1'b0;
        for (int c = 6; c <= 16; c++) begin
            check("shadow_old_cnt", 32'(counter), 32'(c));
            check("shadow_busy", 32'(busy), 32'd1);
            check("shadow_old_out", 32'(out[0]), 32'd0);
            tick();
        end
        for (int c = 0; c <= 16; c++) begin
            check("shadow_new_cnt", 32'(counter), 32'(c));
            check("shadow_idle", 32'(busy), 32'd0);
            check("shadow_new_out", 32'(out[0]), 32'(c < 8));
            tick();
        end

        // Compare boundaries: 0, top, top+1.
        drive_load(1'b0, 16'd16, {16'd1, 16'd16, 16'd17, 16'd0}, 4'b0000);
        tick(); load = 1'b0;
        wait_idle("bound_xfer");
        for (int c = 0; c <= 16; c++) begin
            eo = {1'(c < 1), 1'(c < 16), 1'b1, 1'b0};
            check("bound_out", 32'(out), 32'(eo));
            tick();
        end
        drive_load(1'b0, 16'd0, 64'd1, 4'b0000);
        tick(); load = 1'b0;
        wait_idle("top0_xfer");
        for (int j = 0; j < 5; j++) begin
            check("top0_counter", 32'(counter), 32'd0);
            check("top0_sync", 32'(sync), 32'd1);
            check("top0_out0", 32'(out[0]), 32'd1);
            tick();
        end

        // Enable freeze with a pending load.
        drive_load(1'b0, 16'd16, 64'd8, 4'b0000);
        tick(); load = 1'b0;
        wait_idle("freeze_xfer");
        tick(); tick();
        check("freeze_start", 32'(counter), 32'd2);
        en = 1'b0;
        drive_load(1'b0, 16'd16, 64'd3, 4'b0000);
        tick(); load = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("freeze_counter", 32'(counter), 32'd2);
            check("freeze_out0", 32'(out[0]), 32'd1);
            check("freeze_busy", 32'(busy), 32'd1);
            tick();
        end
        en = 1'b1;

        // Reset mid-period with a pending configuration.
        k = 0;
        while (!(counter == 16'd6 && !busy) && k < 100) begin
            tick();
            k++;
        end
        check("rst_reach6", 32'(counter), 32'd6);
        drive_load(1'b0, 16'd16, 64'd5, 4'b0000);
        tick(); load = 1'b0;
        check("rst_pre_cnt", 32'(counter), 32'd7);
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_counter", 32'(counter), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sync", 32'(sync), 32'd1);

        // Randomized traffic against the reference model.
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 11) == 0);
            mode = 1'($urandom_range(0, 1));
            top  = W'($urandom_range(0, 9));
            for (int i = 0; i < CH; i++) comp[i*W +: W] = W'($urandom_range(0, 11));
            pol  = CH'($urandom_range(0, 15));
            tick();
            model_step();
            check("rnd_counter", 32'(counter), 32'(pcnt(m_pos, a_top, a_mode)));
            check("rnd_out", 32'(out), 32'(model_out()));
            check("rnd_busy", 32'(busy), 32'(m_pend));
            check("rnd_sync", 32'(sync), 32'(pcnt(m_pos, a_top, a_mode) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
